seq_add_sub: RTL and testbench

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

---
 rtl/seq_add_sub.sv | 134 +++++++++++++
 tb/tb_seq_add_sub.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle adder/subtractor, STEP bits per clock, LSB chunk first.
// An operation takes WIDTH/STEP cycles. result/cout/ovf/zero change only
// when an operation completes.
module seq_add_sub #(
    parameter int WIDTH = 10,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [STEP:0]    chunk_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] chunk_ext;
    logic [WIDTH-1:0] psum_next;
    logic             last;
    logic             accept;
    logic             finish;

    // Chunk adder. Subtraction already has ~b stored and carry-in 1.
    // Partial sums shift in from the top, so after N chunks psum_next holds the full result.
    always_comb begin
        chunk_sum = {1'b0, a_sh[STEP-1:0]} + {1'b0, b_sh[STEP-1:0]} + {{STEP{1'b0}}, carry};
        msb_cin   = a_sh[STEP-1] ^ b_sh[STEP-1] ^ chunk_sum[STEP-1];
        chunk_ext = '0;
        chunk_ext[STEP-1:0] = chunk_sum[STEP-1:0];
        psum_next = (psum >> STEP) | (chunk_ext << (WIDTH - STEP));
        last      = (cnt == CW'(N - 1));
    end

    // Next-state logic. Abort takes priority over completion.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand shift registers, running carry, chunk counter and partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            psum  <= '0;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN && !abort) begin
            a_sh  <= a_sh >> STEP;
            b_sh  <= b_sh >> STEP;
            psum  <= psum_next;
            carry <= chunk_sum[STEP];
            cnt   <= cnt + 1'b1;
        end
    end

    // Visible outputs, updated together only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
        end else begin
            done <= finish;
            if (finish) begin
                result <= psum_next;
                cout   <= chunk_sum[STEP];
                ovf    <= msb_cin ^ chunk_sum[STEP];
                zero   <= (psum_next == '0);
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_add_sub.sv
// Testbench for seq_add_sub. Three instances (STEP = 1, 5, 10) run against an
// arithmetic reference model.
module tb_seq_add_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start_f;
    logic       sub;
    logic [9:0] a;
    logic [9:0] b;
    logic       abort;

    logic       busy1, done1, cout1, ovf1, zero1;
    logic [9:0] res1;
    logic       busy5, done5, cout5, ovf5, zero5;
    logic [9:0] res5;
    logic       busy10, done10, cout10, ovf10, zero10;
    logic [9:0] res10;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] RESET_VAL = {10'h000, 1'b0, 1'b0, 1'b1};
    logic [12:0] held1;

    seq_add_sub #(.WIDTH(10), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .abort(abort),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    seq_add_sub #(.WIDTH(10), .STEP(5)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start_f), .sub(sub), .a(a), .b(b), .abort(abort),
        .busy(busy5), .done(done5), .result(res5), .cout(cout5), .ovf(ovf5), .zero(zero5)
    );

    seq_add_sub #(.WIDTH(10), .STEP(10)) u10 (
        .clk(clk), .rst_n(rst_n), .start(start_f), .sub(sub), .a(a), .b(b), .abort(abort),
        .busy(busy10), .done(done10), .result(res10), .cout(cout10), .ovf(ovf10), .zero(zero10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain unsigned/signed arithmetic, packed as {result, cout, ovf, zero}.
    function automatic logic [12:0] model(input logic [9:0] x, input logic [9:0] y, input logic s);
        int ux, uy, sx, sy, ur, sr;
        logic [9:0] r;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = x[9] ? ux - 1024 : ux;
        sy = y[9] ? uy - 1024 : uy;
        if (s) begin
            ur = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy;
            c  = (ur > 1023);
            sr = sx + sy;
        end
        r = 10'(ur);
        o = (sr > 511) || (sr < -512);
        return {r, c, o, (r == 10'h000)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 start pulse mid-run, 2 abort at cycle 5, 3 reset at cycle 5,
    //       4 stop at done cycle so the caller can start back-to-back.
    // pre: start/operands were already driven by the caller.
    task automatic op(input logic [9:0] ia, input logic [9:0] ib, input logic isub,
                      input int mode, input bit pre);
        logic [12:0] m;
        logic [12:0] exp1;
        logic [12:0] expf;
        int d1, d5, d10, c1, c5, c10, last_cyc;
        d1 = 0; d5 = 0; d10 = 0; c1 = -1; c5 = -1; c10 = -1;
        m = model(ia, ib, isub);
        if (!pre) begin
            @(negedge clk);
            a = ia; b = ib; sub = isub; start = 1'b1; start_f = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        start_f = 1'b0;
        check("busy_after_accept", 32'(busy1), 32'd1);
        last_cyc = (mode == 4) ? 10 : 12;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            @(posedge clk);
            #1;
            if (done1)  begin d1++;  if (c1 < 0)  c1 = cyc;  end
            if (done5)  begin d5++;  if (c5 < 0)  c5 = cyc;  end
            if (done10) begin d10++; if (c10 < 0) c10 = cyc; end
            if (cyc == 5 && mode != 2 && mode != 3)
                check("hold_while_busy", 32'({res1, cout1, ovf1, zero1}), 32'(held1));
            if (mode == 1 && cyc == 4) begin
                start = 1'b1; a = ~ia; b = 10'($urandom); sub = ~isub;
            end
            if (mode == 1 && cyc == 5) start = 1'b0;
            if (mode == 2 && cyc == 4) abort = 1'b1;
            if (mode == 2 && cyc == 5) begin
                abort = 1'b0;
                check("busy_after_abort", 32'(busy1), 32'd0);
            end
            if (mode == 3 && cyc == 5) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_outs", 32'({res1, cout1, ovf1, zero1}), 32'(RESET_VAL));
                check("async_rst_busy", 32'(busy1), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        exp1 = (mode == 2) ? held1 : (mode == 3) ? RESET_VAL : m;
        expf = (mode == 3) ? RESET_VAL : m;
        if (mode == 2 || mode == 3) begin
            check("u1_done_count", 32'(d1), 32'd0);
        end else begin
            check("u1_done_count", 32'(d1), 32'd1);
            check("u1_latency", 32'(c1), 32'd10);
        end
        check("u1_outs", 32'({res1, cout1, ovf1, zero1}), 32'(exp1));
        check("u1_busy_end", 32'(busy1), 32'd0);
        check("u5_done_count", 32'(d5), 32'd1);
        check("u5_latency", 32'(c5), 32'd2);
        check("u5_outs", 32'({res5, cout5, ovf5, zero5}), 32'(expf));
        check("u10_done_count", 32'(d10), 32'd1);
        check("u10_latency", 32'(c10), 32'd1);
        check("u10_outs", 32'({res10, cout10, ovf10, zero10}), 32'(expf));
        held1 = exp1;
    endtask

    initial begin
        logic [9:0] ra, rb;
        logic       rs;
        rst_n = 1'b0; start = 1'b0; start_f = 1'b0; sub = 1'b0;
        a = '0; b = '0; abort = 1'b0;
        held1 = RESET_VAL;
        #12;
        check("reset_outs_u1", 32'({res1, cout1, ovf1, zero1}), 32'(RESET_VAL));
        check("reset_busy_done_u1", 32'({busy1, done1}), 32'd0);
        check("reset_outs_u5", 32'({res5, cout5, ovf5, zero5}), 32'(RESET_VAL));
        check("reset_outs_u10", 32'({res10, cout10, ovf10, zero10}), 32'(RESET_VAL));

        // First start is presented with the reset release.
        @(negedge clk);
        rst_n = 1'b1; a = 10'd5; b = 10'd3; sub = 1'b1; start = 1'b1; start_f = 1'b1;
        op(10'd5, 10'd3, 1'b1, 0, 1'b1);

        op(10'd3,   10'd5,   1'b1, 0, 1'b0);
        op(10'h3FF, 10'h001, 1'b0, 0, 1'b0);
        op(10'h1FF, 10'h001, 1'b0, 0, 1'b0);
        op(10'h200, 10'h001, 1'b1, 0, 1'b0);
        op(10'h000, 10'h000, 1'b1, 0, 1'b0);

        op(10'($urandom), 10'($urandom), 1'($urandom), 1, 1'b0);
        op(10'($urandom), 10'($urandom), 1'($urandom), 2, 1'b0);

        // Back-to-back: start driven during the done cycle.
        op(10'($urandom), 10'($urandom), 1'($urandom), 4, 1'b0);
        ra = 10'($urandom); rb = 10'($urandom); rs = 1'($urandom);
        a = ra; b = rb; sub = rs; start = 1'b1; start_f = 1'b1;
        op(ra, rb, rs, 0, 1'b1);

        op(10'($urandom), 10'($urandom), 1'($urandom), 3, 1'b0);

        for (int i = 0; i < 20; i++) begin
            op(10'($urandom), 10'($urandom), 1'($urandom), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
